soc_clken_gen: RTL and testbench
================================

Name: soc_clken_gen

Overview:
Parametrised clock-enable/strobe generator in the SoC clock domain, driven by a single fast clock (e.g. 128 MHz PLL output). Produces NUM_CH derived channels, each with a runtime-programmable divide ratio and phase offset. Each channel provides a one-cycle enable pulse and a square-wave output. A locked flag indicates when all channels are phase-aligned to a common epoch. Replaces fixed PLL divided/phase-shifted outputs with fabric-side programmable timing.

Parameters:
NUM_CH, 3, number of output channels (1..16)
DIV_W, 16, width of divide/phase fields
DEFAULT_DIV, 16, divide ratio loaded into every channel at reset (>=2)
LOCK_CYCLES, 16, cycles after epoch before locked asserts (>=1)

Ports:
refclk  in  1  block clock
rst  in  1  synchronous active-high reset
cfg_wr  in  1  config write strobe, single cycle
cfg_ch  in  max(1,clog2(NUM_CH))  target channel
cfg_div  in  DIV_W  period in refclk cycles
cfg_phase  in  DIV_W  phase offset in refclk cycles relative to epoch
en_out  out  NUM_CH  per-channel one-cycle enable pulse
clk_out  out  NUM_CH  per-channel square wave
locked  out  1  all channels aligned and settled

Behaviour:
- One clock, refclk; reset is synchronous and active-high on rst.
- Reset values: en_out=0, clk_out=0, locked=0, div[i]=DEFAULT_DIV, phase[i]=0, state=ALIGN.
- Config write: on a cycle with cfg_wr=1 and cfg_ch<NUM_CH, div[cfg_ch] and phase[cfg_ch] update at that edge.
  - Stored div = max(cfg_div, 2).
  - Stored phase = min(cfg_phase, stored_div-1).
  - cfg_ch>=NUM_CH: write ignored entirely. No register change, no resync, locked unaffected.
- FSM:
  - ALIGN: exactly one cycle. Outputs forced 0, locked=0. Loads cnt[i] = (div[i]-phase[i]) mod div[i]. Next state is SETTLE.
  - SETTLE: counters run. Settle counter counts LOCK_CYCLES cycles, then go to LOCKED.
  - LOCKED: counters run, locked=1.
  - Any valid cfg_wr in any state: next state ALIGN, so locked is 0 from the cycle after cfg_wr.
  - cfg_wr during ALIGN re-enters ALIGN, which extends ALIGN.
- Epoch: the first cycle after ALIGN.
- Counters: cnt[i] increments 0..div[i]-1, then wraps to 0. Counters run in SETTLE and LOCKED only.
- Output decode (registered, aligned so en_out[i] is high in exactly the cycles where cnt[i]==0):
  - en_out[i]=1 iff cnt[i]==0.
  - clk_out[i]=1 iff cnt[i] < (div[i]+1)>>1. Odd divides give the extra cycle to the high phase.
- Phase result: channel i first pulses at epoch+phase[i], then every div[i] cycles.
- Timing: locked rises at epoch+LOCK_CYCLES and stays high until rst or a valid cfg_wr.
- rst mid-operation: all outputs 0 on the next cycle, config reverts to defaults, full ALIGN/SETTLE sequence follows release.
- No combinational path from inputs to outputs.

Optional Feature:
Macro SOC_CLKEN_GEN_GATE_EN.
- Defined: adds input port ch_gate [NUM_CH].
  - ch_gate[i]=1 forces en_out[i]=0 and clk_out[i]=0 from the next cycle.
  - cnt[i] keeps running, so phase is preserved.
  - Release resumes output on the correct epoch-aligned slot, with no partial high pulse shorter than the nominal high time.
  - Gating does not affect locked.
- Undefined: no ch_gate port, and all channels are always active.

Test Plan:
1. Defaults (NUM_CH=3, div 16, phase 0), release rst -> all en_out pulse at epoch, epoch+16, epoch+32; clk_out 8 high/8 low; locked=1 at epoch+16.
2. Write ch2 div=16 phase=4 while locked -> locked=0 the cycle after cfg_wr; ch2 en_out 4 cycles after ch0/ch1 pulses; locked reasserts 16 cycles after new epoch.
3. Write ch1 div=5 phase=0 -> en_out[1] every 5 cycles; clk_out[1] 3 high/2 low.
4. Write ch0 div=1 -> period 2; write ch0 div=4 phase=7 -> stored phase 3, first pulse at epoch+3.
5. cfg_wr with cfg_ch=3 (NUM_CH=3) while locked -> no register change, locked stays 1, no output disturbance.
6. Assert rst for 1 cycle mid-run with ch2 reprogrammed -> outputs 0 next cycle, ch2 back to div 16 phase 0; with SOC_CLKEN_GEN_GATE_EN, gate ch1 for 20 cycles -> ch1 silent, resumes on original 16-cycle grid.

Source files
------------

// File: rtl/soc_clken_gen.sv
// soc_clken_gen: programmable clock-enable / strobe generator.
//
// Derives NUM_CH channels from refclk. Each channel has a runtime divide ratio and a
// phase offset relative to a common epoch. Each channel drives a one-cycle enable
// pulse and a square wave. locked rises LOCK_CYCLES cycles after the epoch.
//
// Ports:
//   refclk     block clock
//   rst        synchronous active-high reset
//   cfg_wr     config write strobe (single cycle)
//   cfg_ch     target channel; writes to cfg_ch >= NUM_CH are ignored
//   cfg_div    period in refclk cycles (stored as max(cfg_div, 2))
//   cfg_phase  phase offset from epoch (stored as min(cfg_phase, div-1))
//   ch_gate    per-channel output gate (only when SOC_CLKEN_GEN_GATE_EN is defined)
//   en_out     per-channel one-cycle enable pulse
//   clk_out    per-channel square wave; odd divides are high for the extra cycle
//   locked     all channels aligned and settled
//
// Optional feature macro: SOC_CLKEN_GEN_GATE_EN adds the ch_gate input.

module soc_clken_gen #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 16,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
`ifdef SOC_CLKEN_GEN_GATE_EN
    input  logic [NUM_CH-1:0] ch_gate,
`endif
    output logic [NUM_CH-1:0] en_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int unsigned SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StAlign, StSettle, StLocked} state_e;

    state_e state_q, state_d;

    logic                          cfg_valid;
    logic [DIV_W-1:0]              wr_div;
    logic [DIV_W-1:0]              wr_phase;

    logic [NUM_CH-1:0][DIV_W-1:0]  div_q;
    logic [NUM_CH-1:0][DIV_W-1:0]  phase_q;
    logic [NUM_CH-1:0][DIV_W-1:0]  cnt_q, cnt_d;
    logic [SET_W-1:0]              settle_q, settle_d;

    logic                          run_d;
    logic [NUM_CH-1:0]             en_raw;
    logic [NUM_CH-1:0]             clk_raw;
    logic [NUM_CH-1:0]             act;
    logic [NUM_CH-1:0]             en_q, clk_q;

    // ---------------------------------------------------------------------------------
    // Config write sanitising
    // ---------------------------------------------------------------------------------
    assign cfg_valid = cfg_wr && (32'(cfg_ch) < NUM_CH);

    always_comb begin
        wr_div   = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
        wr_phase = (cfg_phase > (wr_div - DIV_W'(1))) ? (wr_div - DIV_W'(1)) : cfg_phase;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                div_q[i]   <= DIV_W'(DEFAULT_DIV);
                phase_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (cfg_valid && (cfg_ch == CH_W'(i))) begin
                    div_q[i]   <= wr_div;
                    phase_q[i] <= wr_phase;
                end
            end
        end
    end

    // ---------------------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= StAlign;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            StAlign:  state_d = StSettle;
            StSettle: begin
                settle_d = settle_q + SET_W'(1);
                if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
                    state_d = StLocked;
                end
            end
            StLocked: state_d = StLocked;
            default:  state_d = StAlign;
        endcase
        // Any accepted write restarts alignment, including one landing in ALIGN itself.
        if (cfg_valid) begin
            state_d = StAlign;
        end
    end

    // FSM: outputs
    always_comb begin
        locked = (state_q == StLocked);
        // Outputs are registered, so they follow the state being entered, not the current one.
        run_d  = (state_d != StAlign);
    end

    // ---------------------------------------------------------------------------------
    // Channel counters and output decode
    // ---------------------------------------------------------------------------------
    always_comb begin
        logic [DIV_W:0] half;
        cnt_d   = cnt_q;
        en_raw  = '0;
        clk_raw = '0;
        half    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (state_q == StAlign) begin
                // Preload so the count reaches 0 exactly phase cycles after the epoch.
                cnt_d[i] = (phase_q[i] == '0) ? '0 : (div_q[i] - phase_q[i]);
            end else if (cnt_q[i] >= (div_q[i] - DIV_W'(1))) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
            half       = ({1'b0, div_q[i]} + (DIV_W + 1)'(1)) >> 1;
            en_raw[i]  = run_d && (cnt_d[i] == '0);
            clk_raw[i] = run_d && ({1'b0, cnt_d[i]} < half);
        end
    end

`ifdef SOC_CLKEN_GEN_GATE_EN
    logic [NUM_CH-1:0] hold_q, hold_d;

    // A gated channel stays silent until the start of a fresh period, so release never
    // produces a truncated high phase.
    always_comb begin
        hold_d = ch_gate | (hold_q & ~en_raw);
        act    = ~hold_d;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign act = '1;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            cnt_q <= '0;
            en_q  <= '0;
            clk_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_raw & act;
            clk_q <= clk_raw & act;
        end
    end

    assign en_out  = en_q;
    assign clk_out = clk_q;

endmodule

// File: tb/tb_soc_clken_gen.sv
module tb_soc_clken_gen;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned DIV_W       = 16;
    localparam int unsigned DEFAULT_DIV = 16;
    localparam int unsigned LOCK_CYCLES = 16;
`ifdef SOC_CLKEN_GEN_GATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
`ifdef SOC_CLKEN_GEN_GATE_EN
    logic [NUM_CH-1:0] ch_gate = '0;
`endif
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;

    soc_clken_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
`ifdef SOC_CLKEN_GEN_GATE_EN
        .ch_gate   (ch_gate),
`endif
        .en_out    (en_out),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: config table plus epoch bookkeeping; waveforms derived from
    // the cycle distance to the epoch.
    int m_div [NUM_CH];
    int m_phase [NUM_CH];
    bit m_blocked [NUM_CH];
    bit m_aligning = 1'b1;
    int m_cyc = 0;
    int m_epoch = 0;
    logic [NUM_CH-1:0] g_cur = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, m_cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit w, input int ch, input int d, input int p,
                        input logic [NUM_CH-1:0] g);
        logic [NUM_CH-1:0] exp_en;
        logic [NUM_CH-1:0] exp_clk;
        logic              exp_locked;
        bit                en_raw;
        bit                clk_raw;
        int                k;
        int                m;
        rst       = r;
        cfg_wr    = w;
        cfg_ch    = 2'(ch);
        cfg_div   = DIV_W'(d);
        cfg_phase = DIV_W'(p);
`ifdef SOC_CLKEN_GEN_GATE_EN
        ch_gate   = g;
`endif
        @(posedge refclk);
        m_cyc++;
        if (r) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                m_div[i]     = int'(DEFAULT_DIV);
                m_phase[i]   = 0;
                m_blocked[i] = 1'b0;
            end
            m_aligning = 1'b1;
        end else if (w && ch < int'(NUM_CH)) begin
            m_div[ch]   = (d < 2) ? 2 : d;
            m_phase[ch] = (p > m_div[ch] - 1) ? m_div[ch] - 1 : p;
            m_aligning  = 1'b1;
        end else if (m_aligning) begin
            m_aligning = 1'b0;
            m_epoch    = m_cyc;
        end
        exp_locked = !m_aligning && ((m_cyc - m_epoch) >= int'(LOCK_CYCLES));
        for (int i = 0; i < int'(NUM_CH); i++) begin
            en_raw  = 1'b0;
            clk_raw = 1'b0;
            if (!m_aligning) begin
                k       = m_cyc - m_epoch;
                m       = (k + m_div[i] - m_phase[i]) % m_div[i];
                en_raw  = (m == 0);
                clk_raw = (m < (m_div[i] + 1) / 2);
            end
            if (GATE_EN && !r) begin
                m_blocked[i] = g[i] || (m_blocked[i] && !en_raw);
            end
            exp_en[i]  = en_raw && !m_blocked[i];
            exp_clk[i] = clk_raw && !m_blocked[i];
        end
        @(negedge refclk);
        check_eq("en_out", 32'(en_out), 32'(exp_en));
        check_eq("clk_out", 32'(clk_out), 32'(exp_clk));
        check_eq("locked", 32'(locked), 32'(exp_locked));
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0, 0, g_cur);
    endtask

    initial begin
        bit r;
        bit w;
        // Defaults out of reset
        repeat (3) step(1'b1, 1'b0, 0, 0, 0, g_cur);
        run(40);
        // Phase shift on ch2 while locked
        step(1'b0, 1'b1, 2, 16, 4, g_cur);
        run(40);
        // Odd divide on ch1
        step(1'b0, 1'b1, 1, 5, 0, g_cur);
        run(30);
        // Divide clamp, then phase clamp
        step(1'b0, 1'b1, 0, 1, 0, g_cur);
        run(30);
        step(1'b0, 1'b1, 0, 4, 7, g_cur);
        run(30);
        // Out-of-range channel must be ignored
        step(1'b0, 1'b1, 3, 7, 2, g_cur);
        run(20);
        // Back-to-back writes extend ALIGN
        step(1'b0, 1'b1, 1, 6, 2, g_cur);
        step(1'b0, 1'b1, 0, 8, 3, g_cur);
        run(30);
        // Reset mid-run with ch2 reprogrammed
        step(1'b0, 1'b1, 2, 9, 5, g_cur);
        run(10);
        step(1'b1, 1'b0, 0, 0, 0, g_cur);
        run(40);
        if (GATE_EN) begin
            g_cur = 3'b010;
            run(20);
            g_cur = '0;
            run(40);
        end
        // Randomised traffic
        repeat (700) begin
            r = ($urandom_range(0, 199) == 0);
            w = ($urandom_range(0, 24) == 0);
            if (GATE_EN && $urandom_range(0, 29) == 0) begin
                g_cur[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
            end
            step(r, w, int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 25)), g_cur);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
